// File: rtl/common_pkg.sv
// Shared types, constants and op-decoding helpers for the iterative mul/div unit.
package common;

  localparam int MULDIV_XLEN = 64;

  // Most negative values of the 32-bit (sign-extended) and 64-bit operand domains
  localparam logic [MULDIV_XLEN-1:0] MIN_W = 64'hFFFF_FFFF_8000_0000;
  localparam logic [MULDIV_XLEN-1:0] MIN_D = 64'h8000_0000_0000_0000;

  typedef enum logic [3:0] {
    OP_MUL,
    OP_MULW,
    OP_DIV,
    OP_DIVU,
    OP_REM,
    OP_REMU,
    OP_DIVW,
    OP_DIVUW,
    OP_REMW,
    OP_REMUW
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV,
    ST_DONE
  } muldiv_state_t;

  function automatic logic is_w_op(input muldiv_op_t op);
    return op inside {OP_MULW, OP_DIVW, OP_DIVUW, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_signed_op(input muldiv_op_t op);
    return op inside {OP_DIV, OP_REM, OP_DIVW, OP_REMW};
  endfunction

  function automatic logic is_rem_op(input muldiv_op_t op);
    return op inside {OP_REM, OP_REMU, OP_REMW, OP_REMUW};
  endfunction

  function automatic logic is_mul_op(input muldiv_op_t op);
    return op inside {OP_MUL, OP_MULW};
  endfunction

  function automatic logic [MULDIV_XLEN-1:0] sext32(input logic [31:0] v);
    return {{(MULDIV_XLEN-32){v[31]}}, v};
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shift-register datapath for shift-add multiply and restoring divide.
// rem doubles as the product accumulator, mcand holds multiplicand or divisor,
// quo holds the multiplier (shifted right) or dividend/quotient (shifted left).
// One XLEN+1-bit adder/subtractor serves both loops.
module muldiv_iter #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            load,
  input  logic            step,
  input  logic            div_mode,
  input  logic [XLEN-1:0] load_mcand,
  input  logic [XLEN-1:0] load_quo,
  output logic [XLEN-1:0] rem_next,
  output logic [XLEN-1:0] quo_next
);

  logic [XLEN-1:0] rem, mcand, quo, mcand_next;
  logic [XLEN:0]   opx, opy, sum;
  logic            ge;

  // Shared adder and next-value selection for one iteration
  always_comb begin
    opx = div_mode ? {rem, quo[XLEN-1]} : {1'b0, rem};
    opy = {1'b0, mcand};
    // Partial remainder is always below twice the divisor, so the
    // XLEN+1-bit difference cannot overflow and its top bit is the sign.
    sum = div_mode ? (opx - opy) : (opx + opy);
    ge  = ~sum[XLEN];
    if (div_mode) begin
      rem_next   = ge ? sum[XLEN-1:0] : opx[XLEN-1:0];
      quo_next   = {quo[XLEN-2:0], ge};
      mcand_next = mcand;
    end else begin
      rem_next   = quo[0] ? sum[XLEN-1:0] : rem;
      quo_next   = {1'b0, quo[XLEN-1:1]};
      mcand_next = {mcand[XLEN-2:0], 1'b0};
    end
  end

  // Datapath registers: cleared on reset, loaded at accept, stepped per iteration
  always_ff @(posedge clk) begin
    if (!reset) begin
      rem   <= '0;
      mcand <= '0;
      quo   <= '0;
    end else if (load) begin
      rem   <= '0;
      mcand <= load_mcand;
      quo   <= load_quo;
    end else if (step) begin
      rem   <= rem_next;
      mcand <= mcand_next;
      quo   <= quo_next;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative multiply/divide unit: handshakes, sequencing FSM, special cases
// and sign fix-up around the muldiv_iter datapath.
//
// state | meaning
// IDLE  | ready for a request
// MUL   | shift-add iterations running
// DIV   | restoring-divide iterations running
// DONE  | result held until execute takes it
module muldiv_ctrl
  import common::*;
#(
  parameter int XLEN = MULDIV_XLEN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            req_valid,
  output logic            req_ready,
  input  muldiv_op_t      req_op,
  input  logic [XLEN-1:0] req_a,
  input  logic [XLEN-1:0] req_b,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_result,
  output logic            busy
);

  muldiv_state_t   state, state_n;
  muldiv_op_t      op_q;
  logic [6:0]      cnt;
  logic            neg_q, neg_r;
  logic [XLEN-1:0] result;

  logic            accept, step, special, op_w, op_s, sign_a, sign_b;
  logic [XLEN-1:0] ea, eb, abs_a, abs_b, a_res, special_res, load_mcand, load_quo;
  logic [XLEN-1:0] rem_next, quo_next, raw, val, fix_res;

  assign accept = req_valid && req_ready && !flush;
  assign step   = (state == ST_MUL || state == ST_DIV) && !flush;

  // Operand extension, magnitudes and special-case detection at accept
  always_comb begin
    op_w   = is_w_op(req_op);
    op_s   = is_signed_op(req_op);
    ea     = op_w ? (op_s ? sext32(req_a[31:0]) : {32'b0, req_a[31:0]}) : req_a;
    eb     = op_w ? (op_s ? sext32(req_b[31:0]) : {32'b0, req_b[31:0]}) : req_b;
    sign_a = op_s & ea[XLEN-1];
    sign_b = op_s & eb[XLEN-1];
    abs_a  = sign_a ? -ea : ea;
    abs_b  = sign_b ? -eb : eb;
    a_res  = op_w ? sext32(req_a[31:0]) : req_a;
    special_res = '0;
    special     = 1'b0;
    if (!is_mul_op(req_op)) begin
      if (eb == '0) begin
        special     = 1'b1;
        special_res = is_rem_op(req_op) ? a_res : '1;
      end else if (op_s && (ea == (op_w ? MIN_W : MIN_D)) && (&eb)) begin
        special     = 1'b1;
        special_res = is_rem_op(req_op) ? '0 : a_res;
      end
    end
    load_mcand = is_mul_op(req_op) ? ea : abs_b;
    // W divides place the 32-bit dividend at the top so 32 shifts consume it
    load_quo   = is_mul_op(req_op) ? eb : (op_w ? {abs_a[31:0], 32'b0} : abs_a);
  end

  muldiv_iter #(.XLEN(XLEN)) u_iter (
    .clk       (clk),
    .reset     (reset),
    .load      (accept),
    .step      (step),
    .div_mode  (!is_mul_op(op_q)),
    .load_mcand(load_mcand),
    .load_quo  (load_quo),
    .rem_next  (rem_next),
    .quo_next  (quo_next)
  );

  // Sign fix-up and W sign-extension applied to the final iteration's values
  always_comb begin
    raw     = (is_mul_op(op_q) || is_rem_op(op_q)) ? rem_next : quo_next;
    val     = (is_rem_op(op_q) ? neg_r : neg_q) ? -raw : raw;
    fix_res = is_w_op(op_q) ? sext32(val[31:0]) : val;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE: if (accept) begin
        if (is_mul_op(req_op)) state_n = ST_MUL;
        else if (special)      state_n = ST_DONE;
        else                   state_n = ST_DIV;
      end
      ST_MUL, ST_DIV: if (cnt == 7'd1) state_n = ST_DONE;
      ST_DONE: if (resp_ready) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
    if (flush) state_n = ST_IDLE;
  end

  // Outputs decoded from state
  always_comb begin
    req_ready  = (state == ST_IDLE);
    resp_valid = (state == ST_DONE);
    busy       = (state != ST_IDLE);
  end

  // Latched op, sign flags, iteration down-counter and result register
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q   <= OP_MUL;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      cnt    <= '0;
      result <= '0;
    end else if (accept) begin
      op_q  <= req_op;
      neg_q <= sign_a ^ sign_b;
      neg_r <= sign_a;
      cnt   <= op_w ? 7'd32 : 7'd64;
      if (special) result <= special_res;
    end else if (step) begin
      cnt <= cnt - 7'd1;
      if (cnt == 7'd1) result <= fix_res;
    end
  end

  assign resp_result = result;

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide unit with its own sequencing FSM for the execute stage. It accepts one M-extension operation at a time from execute over a valid/ready handshake and runs a shift-add multiply or restoring divide loop of 32 or 64 steps. It holds the result until execute takes it. While an operation is in flight it drives `busy`, which the hazard logic uses to stall the fetch, decode and execute stages.

## Interface
Parameters:
- `XLEN`, 64, operand/result width; only 64 is supported.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-low; reset is applied on a rising edge of `clk` when `reset`=0.
- `flush` in 1: abort the current operation and drop any pending response.
- `req_valid` in 1: execute presents an operation.
- `req_ready` out 1: unit can accept an operation; high only in IDLE.
- `req_op` in `muldiv_op_t`: one of MUL, MULW, DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- `req_a` in XLEN: rs1 value.
- `req_b` in XLEN: rs2 value.
- `resp_valid` out 1: `resp_result` is valid; high only in DONE.
- `resp_ready` in 1: execute consumes the result.
- `resp_result` out XLEN: final rd value.
- `busy` out 1: high whenever state is not IDLE.

## Operation
- States:
  - IDLE: `req_valid`=1 and `flush`=0 → latch op and operands; go to MUL, DIV or DONE.
  - MUL / DIV: one iteration per cycle; after the last iteration, apply the sign fix-up and go to DONE.
  - DONE: hold the result; `resp_ready`=1 → IDLE.
- Handshakes:
  - A request is accepted on an edge where `req_valid` and `req_ready` are both 1.
  - A response completes on an edge where `resp_valid` and `resp_ready` are both 1.
  - No request is accepted in the same cycle a response completes.
- Width rules:
  - W ops use `a[31:0]` and `b[31:0]`, sign- or zero-extended according to op, and run N=32 iterations.
  - Non-W ops run N=64 iterations.
  - W results are sign-extended from bit 31.
- MUL/MULW: unsigned shift-add of the low N bits; the low N bits of the product are the result. Signedness is irrelevant for the low half.
- Signed divide/remainder:
  - Operate on absolute values.
  - Negate the quotient if sign(a)≠sign(b); the remainder takes the sign of a.
- Special cases, resolved at accept with no iterations (IDLE → DONE directly):
  - Divisor = 0: quotient = all ones; remainder = a. For W ops, the 32-bit value is sign-extended.
  - Signed overflow (a = most negative value, b = −1): quotient = a; remainder = 0.
- `flush`:
  - Any state → IDLE on the next edge; the result is discarded and `resp_valid` stays 0.
  - `flush`=1 with `req_valid`=1 in IDLE: the request is not accepted.
  - `flush` has priority over `resp_ready` and over iteration.
- Reset (`reset`=0 at an edge): state IDLE, counter 0, all datapath registers 0, regardless of state. Mid-operation reset behaves like flush.

## Timing
- Output values after reset:
  - `req_ready`=1
  - `resp_valid`=0
  - `resp_result`=0
  - `busy`=0
- Request accepted at edge E0:
  - Iterations occur at edges E1..EN.
  - `resp_valid`=1 in the cycle after EN: latency N+1 cycles, i.e. 33 for W ops and 65 for non-W ops.
  - Special cases: `resp_valid`=1 in the cycle after E0 (latency 1).
- `resp_result` and `resp_valid` are registered and stable while waiting for `resp_ready`.
- `busy` rises in the cycle after E0 and falls in the cycle after the response completes or a flush.
- Throughput: at least one IDLE cycle between operations.

## Structure
- Package `common`:
  - `muldiv_op_t` enum.
  - `MULDIV_XLEN`.
  - Helper predicates `is_w_op`, `is_signed_op`, `is_rem_op`.
- Sub-module `muldiv_iter`: multiplicand/remainder/quotient shift registers plus a single XLEN+1-bit adder/subtractor, stepped by an enable.
- `muldiv_ctrl` owns the FSM, the iteration counter (7 bits), special-case detection, sign fix-up and the handshakes.

## Test plan
- DIV a=−7, b=2 → result 0xFFFF_FFFF_FFFF_FFFD after 65 cycles; REM with the same operands → 0xFFFF_FFFF_FFFF_FFFF.
- DIVU a=5, b=0 → 0xFFFF_FFFF_FFFF_FFFF with 1-cycle latency; REMU with the same operands → 5.
- DIV a=0x8000_0000_0000_0000, b=−1 → 0x8000_0000_0000_0000; REMW a=0x8000_0000, b=−1 → 0.
- MULW a=0x7FFF_FFFF, b=2 → 0xFFFF_FFFF_FFFF_FFFE with latency 33; MUL a=0x1_0000_0000, b=0x1_0000_0000 → 0.
- `resp_ready` held low 10 cycles after DONE → `resp_valid` and `resp_result` stable, `req_ready`=0; `resp_ready`=1 → IDLE next cycle.
- `flush` at iteration 20 of DIV → IDLE next cycle with `resp_valid` never asserted; a new request then completes correctly. `reset`=0 mid-MUL → all outputs at their reset values.
